// File: rtl/conv_job_scheduler_if.sv
// Host-side job/completion bus of the convolution job scheduler.
// The host offers jobs (valid/ready) and receives one completion record per job.
interface conv_job_scheduler_if #(
    parameter int SIZE_WIDTH = 5,
    parameter int ID_WIDTH   = 4
);
    logic                  job_valid;
    logic                  job_ready;
    logic [SIZE_WIDTH-1:0] job_size;
    logic [ID_WIDTH-1:0]   job_id;
    logic                  cmp_valid;
    logic [ID_WIDTH-1:0]   cmp_id;
    logic [1:0]            cmp_status;

    // Host side: issues jobs, consumes completions.
    modport master (
        output job_valid, job_size, job_id,
        input  job_ready, cmp_valid, cmp_id, cmp_status
    );

    // Scheduler side: accepts jobs, produces completions.
    modport slave (
        input  job_valid, job_size, job_id,
        output job_ready, cmp_valid, cmp_id, cmp_status
    );
endinterface

// File: rtl/conv_job_scheduler.sv
// Convolution job scheduler: queues host jobs, launches them on the coprocessor
// one at a time, watches for stalls and reports one completion record per job.
module conv_job_scheduler #(
    parameter int SIZE_WIDTH  = 5,
    parameter int ID_WIDTH    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_SIZE    = 31,
    parameter int ACK_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 4096,
    parameter int RST_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_job_scheduler_if.slave   host,
    output logic                  cp_start,
    output logic [SIZE_WIDTH-1:0] cp_size,
    input  logic                  cp_busy,
    input  logic                  cp_done,
    output logic                  cp_rstn,
    output logic                  sched_busy,
    output logic [15:0]           jobs_ok,
    output logic [7:0]            jobs_err
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = SIZE_WIDTH + ID_WIDTH;
    localparam int TMR_MAX = (RUN_TIMEOUT > ACK_TIMEOUT) ? RUN_TIMEOUT : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RCNT_W  = $clog2(RST_CYCLES + 1);

    localparam logic [TMR_W-1:0]    ACK_LIMIT  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]    RUN_LIMIT  = TMR_W'(RUN_TIMEOUT - 1);
    localparam logic [RCNT_W-1:0]   RST_LIMIT  = RCNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [SIZE_WIDTH:0] SIZE_MAX   = (SIZE_WIDTH + 1)'(MAX_SIZE);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_SIZE    = 2'b10;

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, RECOVER} stateType;

    stateType stateReg, stateNext;

    // Job queue: small register file so the head entry is visible in the pop cycle.
    logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtrReg, rdPtrReg;
    logic [CNT_W-1:0]   countReg, countNext;
    logic               jobReadyReg;
    logic               push, pop;

    logic [SIZE_WIDTH-1:0] headSize;
    logic [ID_WIDTH-1:0]   headId;
    logic                  sizeLegal;

    logic [TMR_W-1:0]      timerReg, timerNext;
    logic [RCNT_W-1:0]     rstCntReg, rstCntNext;
    logic                  cpStartReg, cpStartNext;
    logic [SIZE_WIDTH-1:0] cpSizeReg, cpSizeNext;
    logic                  cpRstnReg, cpRstnNext;
    logic [ID_WIDTH-1:0]   curIdReg, curIdNext;
    logic                  cmpValidReg, cmpValidNext;
    logic [ID_WIDTH-1:0]   cmpIdReg, cmpIdNext;
    logic [1:0]            cmpStatusReg, cmpStatusNext;
    logic                  schedBusyReg;
    logic [15:0]           jobsOkReg;
    logic [7:0]            jobsErrReg;
    logic                  okInc, errInc;

    // Ready is registered, so a push can never land on a full queue.
    assign push      = host.job_valid & jobReadyReg;
    assign headSize  = fifoMem[rdPtrReg][ENTRY_W-1:ID_WIDTH];
    assign headId    = fifoMem[rdPtrReg][ID_WIDTH-1:0];
    assign sizeLegal = (headSize != '0) && ({1'b0, headSize} <= SIZE_MAX);

    // Queue storage write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrReg] <= {host.job_size, host.job_id};
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        countNext = countReg;
        if (push && !pop) begin
            countNext = countReg + 1'b1;
        end else if (!push && pop) begin
            countNext = countReg - 1'b1;
        end
    end

    // Queue pointers, occupancy and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            jobReadyReg <= 1'b1;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + 1'b1;
            if (pop)  rdPtrReg <= rdPtrReg + 1'b1;
            countReg    <= countNext;
            jobReadyReg <= (countNext != FULL_COUNT);
        end
    end

    // Next state and next value of every registered output.
    always_comb begin
        stateNext     = stateReg;
        timerNext     = '0;
        rstCntNext    = rstCntReg;
        cpStartNext   = 1'b0;
        cpSizeNext    = cpSizeReg;
        cpRstnNext    = 1'b1;
        curIdNext     = curIdReg;
        cmpValidNext  = 1'b0;
        cmpIdNext     = cmpIdReg;
        cmpStatusNext = cmpStatusReg;
        pop           = 1'b0;
        okInc         = 1'b0;
        errInc        = 1'b0;
        case (stateReg)
            IDLE: begin
                if (countReg != '0) begin
                    pop = 1'b1;
                    if (sizeLegal) begin
                        stateNext   = LAUNCH;
                        cpStartNext = 1'b1;
                        cpSizeNext  = headSize;
                        curIdNext   = headId;
                    end else begin
                        // Illegal size never reaches the coprocessor.
                        cmpValidNext  = 1'b1;
                        cmpIdNext     = headId;
                        cmpStatusNext = ST_SIZE;
                        errInc        = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                cpStartNext = 1'b1;
                if (cp_busy) begin
                    cpStartNext = 1'b0;
                    if (cp_done) begin
                        // Very short job: acknowledged and finished in one cycle.
                        stateNext     = GAP;
                        cmpValidNext  = 1'b1;
                        cmpIdNext     = curIdReg;
                        cmpStatusNext = ST_OK;
                        okInc         = 1'b1;
                    end else begin
                        stateNext = RUN;
                    end
                end else if (timerReg == ACK_LIMIT) begin
                    cpStartNext   = 1'b0;
                    stateNext     = RECOVER;
                    cpRstnNext    = 1'b0;
                    rstCntNext    = '0;
                    cmpValidNext  = 1'b1;
                    cmpIdNext     = curIdReg;
                    cmpStatusNext = ST_TIMEOUT;
                    errInc        = 1'b1;
                end else begin
                    timerNext = timerReg + 1'b1;
                end
            end
            RUN: begin
                if (cp_done) begin
                    stateNext     = GAP;
                    cmpValidNext  = 1'b1;
                    cmpIdNext     = curIdReg;
                    cmpStatusNext = ST_OK;
                    okInc         = 1'b1;
                end else if (timerReg == RUN_LIMIT) begin
                    stateNext     = RECOVER;
                    cpRstnNext    = 1'b0;
                    rstCntNext    = '0;
                    cmpValidNext  = 1'b1;
                    cmpIdNext     = curIdReg;
                    cmpStatusNext = ST_TIMEOUT;
                    errInc        = 1'b1;
                end else begin
                    timerNext = timerReg + 1'b1;
                end
            end
            GAP: begin
                // Start stays low here, so consecutive jobs always see a low gap.
                if (!cp_busy) begin
                    stateNext = IDLE;
                end
            end
            RECOVER: begin
                cpRstnNext = 1'b0;
                if (rstCntReg == RST_LIMIT) begin
                    cpRstnNext = 1'b1;
                    stateNext  = IDLE;
                end else begin
                    rstCntNext = rstCntReg + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg     <= IDLE;
            timerReg     <= '0;
            rstCntReg    <= '0;
            cpStartReg   <= 1'b0;
            cpSizeReg    <= '0;
            cpRstnReg    <= 1'b0;
            curIdReg     <= '0;
            cmpValidReg  <= 1'b0;
            cmpIdReg     <= '0;
            cmpStatusReg <= '0;
            schedBusyReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            timerReg     <= timerNext;
            rstCntReg    <= rstCntNext;
            cpStartReg   <= cpStartNext;
            cpSizeReg    <= cpSizeNext;
            cpRstnReg    <= cpRstnNext;
            curIdReg     <= curIdNext;
            cmpValidReg  <= cmpValidNext;
            cmpIdReg     <= cmpIdNext;
            cmpStatusReg <= cmpStatusNext;
            schedBusyReg <= (stateNext != IDLE) || (countNext != '0);
        end
    end

    // Completion counters: ok wraps, errors saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobsOkReg  <= '0;
            jobsErrReg <= '0;
        end else begin
            if (okInc) jobsOkReg <= jobsOkReg + 1'b1;
            if (errInc && (jobsErrReg != 8'hFF)) jobsErrReg <= jobsErrReg + 1'b1;
        end
    end

    assign host.job_ready  = jobReadyReg;
    assign host.cmp_valid  = cmpValidReg;
    assign host.cmp_id     = cmpIdReg;
    assign host.cmp_status = cmpStatusReg;
    assign cp_start        = cpStartReg;
    assign cp_size         = cpSizeReg;
    assign cp_rstn         = cpRstnReg;
    assign sched_busy      = schedBusyReg;
    assign jobs_ok         = jobsOkReg;
    assign jobs_err        = jobsErrReg;
endmodule
